trng_seq_ctrl: RTL
==================

# trng_seq_ctrl

Sequencing controller for the HSM ring-oscillator TRNG sampler. Owns the sampler's enable, sample-trigger and clear inputs, runs a clear/warm-up/sample cycle, applies a repetition-count health test to every 32-bit word, and buffers accepted words in a small FIFO behind a valid/ready stream. Sits between the sampler and the AXI-Lite register wrapper; the wrapper drives the run and error-clear controls and pops words.

## Interface
- WARMUP_CYCLES, 256, cycles of oscillator run time after clear before the first trigger
- TIMEOUT_CYCLES, 1024, maximum cycles to wait for `osc_running` or for a new sample
- RCT_LIMIT, 4, number of consecutive identical words that declares a health failure (≥2)
- FIFO_DEPTH, 4, accepted-word buffer depth (power of 2)

Ports:
- clk  in  1  sole clock
- rst  in  1  synchronous, active-high reset
- run  in  1  level; 1 = keep the FIFO topped up
- err_clear  in  1  single-cycle pulse; leaves HALT and clears sticky errors
- trng_enable  out  1  to sampler enable
- trng_sample_trig  out  1  to sampler sample_trig, one-cycle pulse
- trng_clear  out  1  to sampler clear
- trng_random  in  32  sampler random_out
- trng_sample_count  in  32  sampler sample_count
- trng_osc_running  in  1  sampler osc_running
- rnd_data  out  32  FIFO head
- rnd_valid  out  1  FIFO not empty
- rnd_ready  in  1  consumer pop
- fifo_level  out  $clog2(FIFO_DEPTH)+1  current occupancy
- busy  out  1  state ≠ IDLE and state ≠ HALT
- health_fail  out  1  sticky repetition-test failure
- timeout_err  out  1  sticky oscillator or sample timeout

## Operation
- States: IDLE, CLEAR, WARMUP, TRIG, WAIT, CHECK, HALT.
- IDLE: all sampler outputs are 0. `run`=1 moves to CLEAR.
- CLEAR (1 cycle): `trng_clear`=1 and `trng_enable`=0. Flushes the FIFO, clears `prev_valid`, and sets `rep_cnt`=0. Moves to WARMUP.
- WARMUP: `trng_enable`=1. Counts WARMUP_CYCLES cycles, then:
  - if `trng_osc_running`=1, moves to TRIG;
  - otherwise keeps waiting up to TIMEOUT_CYCLES more; on expiry sets `timeout_err` and moves to HALT.
- TRIG: enable stays 1. If the FIFO is not full, pulses `trng_sample_trig`, latches `ref_cnt` = `trng_sample_count`, and moves to WAIT. If the FIFO is full, stays in TRIG.
- WAIT: when `trng_sample_count` ≠ `ref_cnt`, moves to CHECK. After TIMEOUT_CYCLES cycles without a change, sets `timeout_err` and moves to HALT.
- CHECK (1 cycle): compares `trng_random` with `prev_word`.
  - If equal and `prev_valid`, `rep_cnt`++; otherwise `rep_cnt`=1.
  - If the new `rep_cnt` equals RCT_LIMIT: the word is dropped, `health_fail` is set, and the block moves to HALT.
  - Otherwise: the word is pushed to the FIFO, `prev_word` is updated, `prev_valid`=1, and the block moves to TRIG.
- HALT: `trng_enable`=0, no triggers, FIFO holds its contents and `rnd_valid` still drains. `err_clear` clears both sticky flags and moves to IDLE.
- `run`=0 in CLEAR/WARMUP/TRIG/WAIT/CHECK returns to IDLE next cycle. A pending sample is abandoned and the CHECK word is not pushed. FIFO contents are retained.
- `err_clear` outside HALT is ignored.
- FIFO push only occurs in CHECK, and TRIG is gated on not-full, so a push never hits a full FIFO. Push and pop in the same cycle leave the level unchanged. Pop when empty is ignored.
- Counter arithmetic: timeout counters saturate. `ref_cnt` compare is inequality, so `sample_count` wrap-around is safe.

## Timing
- Reset values: all outputs 0; state IDLE; FIFO empty; `fifo_level`=0.
- All outputs are registered. The sampler controls reflect the state the block is in.
- The `run` rise to `trng_clear` high latency is 1 cycle. The first trigger comes at CLEAR + 1 + WARMUP_CYCLES cycles if the oscillator is running.
- The sample change seen in WAIT is detected the same cycle, and the word appears on `rnd_data`/`rnd_valid` 2 cycles later (CHECK, then FIFO write).
- `rnd_data` is valid whenever `rnd_valid`=1 and is stable until popped (`rnd_valid`&&`rnd_ready` at a clock edge).
- `rst` mid-operation: everything returns to reset values on the next edge; FIFO is discarded.

## Structure
- Package `hsm_trng_pkg`: state enum `trng_seq_state_t`, default parameter constants, and status bit positions for the wrapper's status register.
- Sub-module `trng_rnd_fifo`: synchronous FIFO with push, pop, flush, level, and head data. The controller FSM, counters and health test live in the top module.

## Test plan
The bench models the sampler (`sample_count`++ 3 cycles after a trigger, scripted `random_out`) and uses WARMUP_CYCLES=8, TIMEOUT_CYCLES=16, RCT_LIMIT=3, FIFO_DEPTH=4.

- Reset with `run`=1: all outputs are 0 while `rst`=1. After release, `trng_clear` is high 1 cycle and the first `trng_sample_trig` comes 9 cycles later.
- Words A, B, C, D, E with `rnd_ready`=0: `fifo_level` reaches 4, exactly 4 triggers occur, and TRIG stalls. Popping 1 gives `rnd_data`=A and exactly one new trigger follows.
- Words 0x5A5A5A5A ×3: two are pushed, `health_fail`=1, state HALT, `trng_enable`=0. `err_clear` returns to IDLE with both flags 0.
- `osc_running` held 0: `timeout_err` is set 8+16 cycles after WARMUP entry, then HALT.
- Sampler never increments: `timeout_err` is set 16 cycles after the trigger.
- `run` dropped during WAIT: IDLE on the next cycle, no push, FIFO level unchanged. A simultaneous push/pop at level 2 keeps the level at 2.

Source files
------------

// File: rtl/hsm_trng_pkg.sv
// Shared types and constants for the HSM TRNG sequencing controller and its
// register wrapper.
package hsm_trng_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_WARMUP,
    ST_TRIG,
    ST_WAIT,
    ST_CHECK,
    ST_HALT
  } trng_seq_state_t;

  localparam int DEF_WARMUP_CYCLES  = 256;
  localparam int DEF_TIMEOUT_CYCLES = 1024;
  localparam int DEF_RCT_LIMIT      = 4;
  localparam int DEF_FIFO_DEPTH     = 4;

  // Bit positions in the wrapper's status register
  localparam int STAT_BUSY        = 0;
  localparam int STAT_RND_VALID   = 1;
  localparam int STAT_HEALTH_FAIL = 2;
  localparam int STAT_TIMEOUT_ERR = 3;
  localparam int STAT_LEVEL_LSB   = 4;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/trng_rnd_fifo.sv
// Small synchronous FIFO buffering accepted random words; head is shown
// whenever valid and only advances on pop.
module trng_rnd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;
  logic [LW-1:0]    level_nxt;

  assign do_pop    = pop && valid;
  assign do_push   = push && (level != LW'(DEPTH));
  assign level_nxt = level + LW'(do_push) - LW'(do_pop);
  assign head      = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      if (rst) begin
        for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level_nxt;
      valid <= (level_nxt != '0);
    end
  end

endmodule

// File: rtl/trng_seq_ctrl.sv
// Sequencer for the ring-oscillator TRNG sampler: clear/warm-up/sample loop,
// repetition-count health test and an output word FIFO.
//
// state     | meaning
// IDLE      | sampler off, waiting for run
// CLEAR     | one-cycle sampler clear, FIFO flush, health test reset
// WARMUP    | oscillator settling, then wait for osc_running
// TRIG      | fire a sample trigger once the FIFO has room
// WAIT      | wait for sample_count to move
// CHECK     | repetition test, push or declare health failure
// HALT      | sampler off until err_clear; FIFO still drains
module trng_seq_ctrl
  import hsm_trng_pkg::*;
#(
  parameter int WARMUP_CYCLES  = DEF_WARMUP_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int RCT_LIMIT      = DEF_RCT_LIMIT,
  parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          run,
  input  logic                          err_clear,
  output logic                          trng_enable,
  output logic                          trng_sample_trig,
  output logic                          trng_clear,
  input  logic [31:0]                   trng_random,
  input  logic [31:0]                   trng_sample_count,
  input  logic                          trng_osc_running,
  output logic [31:0]                   rnd_data,
  output logic                          rnd_valid,
  input  logic                          rnd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          health_fail,
  output logic                          timeout_err
);

  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TMR_W = $clog2(max2(WARMUP_CYCLES, TIMEOUT_CYCLES) + 1);
  localparam int REP_W = $clog2(RCT_LIMIT + 1);

  localparam logic [TMR_W-1:0] WARM_LOAD = TMR_W'(WARMUP_CYCLES - 1);
  localparam logic [TMR_W-1:0] TMO_LOAD  = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL  = LVL_W'(FIFO_DEPTH);
  localparam logic [REP_W-1:0] REP_LIM   = REP_W'(RCT_LIMIT);

  trng_seq_state_t  state;
  logic [TMR_W-1:0] tmr;
  logic             warm_done;
  logic [31:0]      ref_cnt;
  logic [31:0]      prev_word;
  logic             prev_valid;
  logic [REP_W-1:0] rep_cnt;

  logic [REP_W-1:0] rep_new;
  logic             fifo_push;
  logic             fifo_flush;
  logic             fifo_pop_fire;
  logic [LVL_W-1:0] lvl_next;
  logic             full_next;

  assign rep_new       = (prev_valid && (trng_random == prev_word)) ? rep_cnt + 1'b1 : REP_W'(1);
  assign fifo_flush    = (state == ST_CLEAR);
  assign fifo_push     = (state == ST_CHECK) && run && (rep_new != REP_LIM);
  assign fifo_pop_fire = rnd_valid && rnd_ready;

  // Trigger decisions are registered, so they look at the FIFO level after this edge
  always_comb begin
    lvl_next = fifo_level;
    if (fifo_flush) lvl_next = '0;
    else            lvl_next = fifo_level + LVL_W'(fifo_push) - LVL_W'(fifo_pop_fire);
  end
  assign full_next = (lvl_next == LVL_FULL);

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      tmr              <= '0;
      warm_done        <= 1'b0;
      ref_cnt          <= '0;
      prev_word        <= '0;
      prev_valid       <= 1'b0;
      rep_cnt          <= '0;
      trng_enable      <= 1'b0;
      trng_sample_trig <= 1'b0;
      trng_clear       <= 1'b0;
      busy             <= 1'b0;
      health_fail      <= 1'b0;
      timeout_err      <= 1'b0;
    end else begin
      trng_sample_trig <= 1'b0;
      trng_clear       <= 1'b0;
      if (tmr != '0) tmr <= tmr - 1'b1;

      if (!run && (state inside {ST_CLEAR, ST_WARMUP, ST_TRIG, ST_WAIT, ST_CHECK})) begin
        state       <= ST_IDLE;
        trng_enable <= 1'b0;
        busy        <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (run) begin
              state      <= ST_CLEAR;
              trng_clear <= 1'b1;
              busy       <= 1'b1;
            end
          end
          ST_CLEAR: begin
            state       <= ST_WARMUP;
            trng_enable <= 1'b1;
            tmr         <= WARM_LOAD;
            warm_done   <= 1'b0;
            prev_valid  <= 1'b0;
            rep_cnt     <= '0;
          end
          ST_WARMUP: begin
            if ((tmr == '0) || warm_done) begin
              if (trng_osc_running) begin
                state            <= ST_TRIG;
                trng_sample_trig <= !full_next;
                if (!full_next) tmr <= TMO_LOAD;
              end else if (!warm_done) begin
                warm_done <= 1'b1;
                tmr       <= TMO_LOAD;
              end else if (tmr == '0) begin
                timeout_err <= 1'b1;
                state       <= ST_HALT;
                trng_enable <= 1'b0;
                busy        <= 1'b0;
              end
            end
          end
          ST_TRIG: begin
            if (trng_sample_trig) begin
              state   <= ST_WAIT;
              ref_cnt <= trng_sample_count;
            end else begin
              trng_sample_trig <= !full_next;
              if (!full_next) tmr <= TMO_LOAD;
            end
          end
          ST_WAIT: begin
            if (trng_sample_count != ref_cnt) begin
              state <= ST_CHECK;
            end else if (tmr == '0) begin
              timeout_err <= 1'b1;
              state       <= ST_HALT;
              trng_enable <= 1'b0;
              busy        <= 1'b0;
            end
          end
          ST_CHECK: begin
            if (rep_new == REP_LIM) begin
              health_fail <= 1'b1;
              state       <= ST_HALT;
              trng_enable <= 1'b0;
              busy        <= 1'b0;
            end else begin
              prev_word        <= trng_random;
              prev_valid       <= 1'b1;
              rep_cnt          <= rep_new;
              state            <= ST_TRIG;
              trng_sample_trig <= !full_next;
              if (!full_next) tmr <= TMO_LOAD;
            end
          end
          ST_HALT: begin
            if (err_clear) begin
              health_fail <= 1'b0;
              timeout_err <= 1'b0;
              state       <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  trng_rnd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (32)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (trng_random),
    .pop       (rnd_ready),
    .head      (rnd_data),
    .valid     (rnd_valid),
    .level     (fifo_level)
  );

endmodule
